// File: rtl/alu_multiword_seq_if.sv
// alu_multiword_seq_if: operation request (start/cmd/a_in/b_in), ALU slice drive (alu_a/alu_b/alu_carry/alu_op, alu_y back) and result/flag/status bundle
interface alu_multiword_seq_if #(
  parameter int N = 8,
  parameter int WORDS = 4
);
  logic start;
  logic [2:0] cmd;
  logic [WORDS*N-1:0] a_in;
  logic [WORDS*N-1:0] b_in;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic alu_carry;
  logic [3:0] alu_op;
  logic [N:0] alu_y;
  logic [WORDS*N-1:0] result;
  logic carry_out;
  logic zero_out;
  logic busy;
  logic done;
  modport slave (
    input start, cmd, a_in, b_in, alu_y,
    output alu_a, alu_b, alu_carry, alu_op, result, carry_out, zero_out, busy, done
  );
  modport master (
    output start, cmd, a_in, b_in, alu_y,
    input alu_a, alu_b, alu_carry, alu_op, result, carry_out, zero_out, busy, done
  );
endinterface

// File: rtl/alu_multiword_seq.sv
// alu_multiword_seq: WORDS x N-bit sequencer feeding a combinational ALU one slice per cycle; ports clk, reset (async high), bus (slave: start/cmd/a_in/b_in in, alu_* drive, alu_y back, result/carry_out/zero_out/busy/done out)
module alu_multiword_seq #(
  parameter int N = 8,
  parameter int WORDS = 4
) (
  input logic clk,
  input logic reset,
  alu_multiword_seq_if.slave bus
);
  localparam int IW = $clog2(WORDS);
  localparam int W = WORDS * N;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_a, r_b, r_result, w_res_nxt;
  logic [2:0] r_cmd;
  logic [IW-1:0] r_idx;
  logic r_carry, r_cout, r_zero;
  logic w_desc, w_first, w_last, w_chain, w_carry_nxt, w_run;
  logic [3:0] w_op;
  assign w_run = r_state == RUN;
  assign w_desc = r_cmd == 3'd6;
  assign w_first = r_idx == (w_desc ? IW'(WORDS - 1) : '0);
  assign w_last = r_idx == (w_desc ? '0 : IW'(WORDS - 1));
  assign w_chain = r_cmd <= 3'd1 || r_cmd == 3'd5 || r_cmd == 3'd6;
  assign w_carry_nxt = w_chain & bus.alu_y[N];
  assign bus.result = r_result;
  assign bus.carry_out = r_cout;
  assign bus.zero_out = r_zero;
  always_comb begin
    w_op = 4'h1;
    case (r_cmd)
      3'd0: w_op = w_first ? 4'hc : 4'he;
      3'd1: w_op = w_first ? 4'hd : 4'hf;
      3'd2: w_op = 4'h9;
      3'd3: w_op = 4'h8;
      3'd4: w_op = 4'ha;
      3'd5: w_op = w_first ? 4'h4 : 4'h6;
      3'd6: w_op = w_first ? 4'h5 : 4'h7;
      default: w_op = 4'h1;
    endcase
  end
  always_comb begin
    w_res_nxt = r_result;
    w_res_nxt[r_idx*N +: N] = bus.alu_y[N-1:0];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = bus.start ? RUN : IDLE;
      RUN: w_next = w_last ? DONE : RUN;
      default: w_next = IDLE;
    endcase
    bus.busy = w_run;
    bus.done = r_state == DONE;
    bus.alu_a = w_run ? r_a[r_idx*N +: N] : '0;
    bus.alu_b = w_run ? r_b[r_idx*N +: N] : '0;
    bus.alu_carry = w_run & r_carry;
    bus.alu_op = w_run ? w_op : 4'h0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_cmd <= '0;
      r_idx <= '0;
      r_carry <= 1'b0;
      r_result <= '0;
      r_cout <= 1'b0;
      r_zero <= 1'b0;
    end else if (r_state == IDLE && bus.start) begin
      r_a <= bus.a_in;
      r_b <= bus.b_in;
      r_cmd <= bus.cmd;
      r_idx <= bus.cmd == 3'd6 ? IW'(WORDS - 1) : '0;
      r_carry <= 1'b0;
      r_result <= '0;
    end else if (w_run) begin
      r_result <= w_res_nxt;
      r_carry <= w_carry_nxt;
      if (!w_last) r_idx <= w_desc ? r_idx - 1'b1 : r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_carry_nxt;
        r_zero <= w_res_nxt == '0;
      end
    end
endmodule

// File: tb/tb_alu_multiword_seq.sv
// tb_alu_multiword_seq: random and directed checks of the slice sequencer against whole-word arithmetic, with a behavioural ALU closing the loop
module tb_alu_multiword_seq;
  localparam int N = 8;
  localparam int WORDS = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  alu_multiword_seq_if #(.N(N), .WORDS(WORDS)) bus ();
  alu_multiword_seq #(.N(N), .WORDS(WORDS)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic c);
    case (op)
      4'h1: return {1'b0, a};
      4'h4: return {a, 1'b0};
      4'h5: return {a[0], 1'b0, a[7:1]};
      4'h6: return {a, c};
      4'h7: return {a[0], c, a[7:1]};
      4'h8: return {1'b0, a | b};
      4'h9: return {1'b0, a & b};
      4'ha: return {1'b0, a ^ b};
      4'hc: return {1'b0, a} + {1'b0, b};
      4'hd: return {1'b0, a} - {1'b0, b};
      4'he: return {1'b0, a} + {1'b0, b} + {8'd0, c};
      4'hf: return {1'b0, a} - {1'b0, b} - {8'd0, c};
      default: return '0;
    endcase
  endfunction
  assign bus.alu_y = alu_f(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_carry);
  function automatic logic [32:0] ref_f(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {1'b0, a} - {1'b0, b};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {a, 1'b0};
      3'd6: return {a[0], 1'b0, a[31:1]};
      default: return {1'b0, a};
    endcase
  endfunction
  function automatic logic [15:0] exp_ops(input logic [2:0] c);
    logic [3:0] f, l;
    logic [15:0] s;
    case (c)
      3'd0: begin f = 4'hc; l = 4'he; end
      3'd1: begin f = 4'hd; l = 4'hf; end
      3'd2: begin f = 4'h9; l = 4'h9; end
      3'd3: begin f = 4'h8; l = 4'h8; end
      3'd4: begin f = 4'ha; l = 4'ha; end
      3'd5: begin f = 4'h4; l = 4'h6; end
      3'd6: begin f = 4'h5; l = 4'h7; end
      default: begin f = 4'h1; l = 4'h1; end
    endcase
    s = {12'd0, f};
    for (int i = 1; i < WORDS; i++) s = {s[11:0], l};
    return s;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [32:0] r;
    logic [15:0] ops;
    int busy_n, done_n;
    r = ref_f(c, a, b);
    ops = '0;
    busy_n = 0;
    done_n = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.cmd = c;
    bus.a_in = a;
    bus.b_in = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a_in = $urandom;
    bus.b_in = $urandom;
    bus.cmd = 3'($urandom_range(0, 7));
    for (int k = 0; k < WORDS; k++) begin
      @(negedge clk);
      busy_n += int'(bus.busy);
      done_n += int'(bus.done);
      ops = {ops[11:0], bus.alu_op};
      if (poke && k == 1) bus.start = 1'b1;
      if (poke && k == WORDS - 1) bus.start = 1'b0;
    end
    check($sformatf("busy cycles cmd%0d", c), 64'(busy_n), 64'(WORDS));
    check($sformatf("early done cmd%0d", c), 64'(done_n), 64'd0);
    check($sformatf("op seq cmd%0d", c), 64'(ops), 64'(exp_ops(c)));
    @(negedge clk);
    check($sformatf("done pulse cmd%0d", c), {62'd0, bus.done, bus.busy}, 64'b10);
    check($sformatf("result cmd%0d", c), 64'(bus.result), 64'(r[31:0]));
    check($sformatf("flags cmd%0d", c), {62'd0, bus.carry_out, bus.zero_out}, {62'd0, r[32], r[31:0] == 32'd0});
    check($sformatf("idle op cmd%0d", c), 64'(bus.alu_op), 64'd0);
    @(negedge clk);
    check($sformatf("done clear cmd%0d", c), {62'd0, bus.done, bus.busy}, 64'd0);
    if (poke) begin
      @(negedge clk);
      check("no restart", {62'd0, bus.done, bus.busy}, 64'd0);
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.cmd = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    repeat (2) @(negedge clk);
    check("reset status", {bus.busy, bus.done, bus.carry_out, bus.zero_out}, 64'd0);
    check("reset result", 64'(bus.result), 64'd0);
    check("reset drive", {bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_carry}, 64'd0);
    reset = 1'b0;
    run_op(3'd0, 32'h000000ff, 32'h00000001, 1'b0);
    run_op(3'd1, 32'h00000000, 32'h00000001, 1'b0);
    run_op(3'd6, 32'h00000101, 32'h0, 1'b0);
    run_op(3'd4, 32'ha5a5a5a5, 32'ha5a5a5a5, 1'b1);
    run_op(3'd5, 32'h80000000, 32'h0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.cmd = 3'd0;
    bus.a_in = 32'h11111111;
    bus.b_in = 32'h22222222;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid reset status", {bus.busy, bus.done, bus.carry_out, bus.zero_out}, 64'd0);
    check("mid reset result", 64'(bus.result), 64'd0);
    check("mid reset drive", {bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_carry}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(3'd0, 32'h1, 32'h1, 1'b0);
    for (int i = 0; i < 24; i++)
      run_op(3'($urandom_range(0, 7)), (i % 4 == 0) ? 32'hffffffff : 32'($urandom), 32'($urandom), 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_multiword_seq.md
Name: alu_multiword_seq

Overview:
Multi-precision sequencer that sits directly upstream of the ALU. It accepts one WORDS×N-bit operation and drives the ALU's A, B, carry and aluop inputs one N-bit slice per cycle. It consumes the ALU's N+1-bit Y output slice by slice, chaining carry/borrow through ADC/SBB/ROL/ROR. It assembles the full-width result and flags for the downstream register stage.

Parameters:
N, 8, slice width; must match the ALU's N.
WORDS, 4, number of slices per operand (≥2).

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request a new operation; sampled only in IDLE.
cmd  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 PASS A.
a_in  input  WORDS*N  operand A; captured on an accepted start.
b_in  input  WORDS*N  operand B; captured on an accepted start.
alu_a  output  N  current A slice to the ALU.
alu_b  output  N  current B slice to the ALU.
alu_carry  output  1  chained carry to the ALU.
alu_op  output  4  ALU opcode, using the ALU's 4-bit encoding.
alu_y  input  N+1  ALU result; bit N is carry/borrow out.
result  output  WORDS*N  assembled result; held until the next accepted start.
carry_out  output  1  final carry/borrow/shifted-out bit.
zero_out  output  1  1 when result == 0.
busy  output  1  high while slices are processed.
done  output  1  one-cycle pulse when result and flags are valid.

Behaviour:
- States: IDLE → RUN → DONE → IDLE.
  - IDLE & start: latch a_in, b_in, cmd; clear the internal carry and result register; set slice index; go to RUN.
  - RUN: lasts exactly WORDS cycles. DONE lasts 1 cycle.
- Slice order:
  - Ascending (slice 0 = LSB first) for ADD, SUB, AND, OR, XOR, SHL, PASS.
  - Descending (MSB slice first) for SHR.
- alu_op per slice, with first slice / later slices:
  - ADD: 4'hc / 4'he (ADC).
  - SUB: 4'hd / 4'hf (SBB).
  - SHL: 4'h4 (ASL) / 4'h6 (ROL).
  - SHR: 4'h5 (LSR) / 4'h7 (ROR).
  - AND 4'h9, OR 4'h8, XOR 4'ha, PASS 4'h1, on all slices.
- alu_carry: the internal carry register, which is 0 on the first slice.
- The ALU is combinational. Each RUN cycle, at the clock edge:
  - alu_y[N-1:0] is written to the current result slice.
  - For ADD/SUB/SHL, the internal carry takes alu_y[N].
  - For SHR, the internal carry takes alu_y[N] (the ALU returns the shifted-out bit A[0] there).
  - For logic ops and PASS, the internal carry is 0.
- Outputs in IDLE/DONE: alu_op = 4'h0 (ZERO), alu_a = 0, alu_b = 0, alu_carry = 0.
- carry_out and zero_out update on the RUN→DONE edge. zero_out compares the full assembled result.
- busy = 1 exactly in RUN. done = 1 exactly in DONE.
- Latency: start accepted on edge 0; busy is high for cycles 1..WORDS; done is high in cycle WORDS+1. The next start can be accepted in the DONE cycle +1, i.e. back in IDLE.
- start while in RUN or DONE is ignored, with no queuing. a_in, b_in and cmd changes after acceptance have no effect.
- Width rules:
  - SUB wraps modulo 2^(WORDS*N); carry_out = 1 means a borrow occurred.
  - SHL/SHR shift the whole word by 1. The vacated bit is 0 and the shifted-out bit goes to carry_out.
- Reset (at any time, including mid-RUN): state = IDLE; result, carry_out, zero_out, busy, done, internal carry = 0; ALU drive outputs = 0. No partial result survives.

Test Plan:
- ADD with N=8, WORDS=4: a=0x000000FF, b=0x00000001 → result 0x00000100, carry_out 0, zero_out 0. busy high for 4 cycles; done pulses in cycle 5.
- SUB: a=0x00000000, b=0x00000001 → result 0xFFFFFFFF, carry_out 1. Alu_op sequence observed as d, f, f, f.
- SHL: a=0x80000000 → result 0x00000000, carry_out 1, zero_out 1. Alu_op sequence 4, 6, 6, 6.
- SHR: a=0x00000101 → result 0x00000080, carry_out 1. Slices are processed MSB first; alu_op sequence 5, 7, 7, 7.
- XOR: a=0xA5A5A5A5, b=0xA5A5A5A5 → result 0, zero_out 1, carry_out 0. A second start pulsed during busy is ignored, and no extra done pulse occurs.
- Reset asserted in the 2nd RUN cycle of an ADD → busy, done, result and flags are 0 immediately. A fresh ADD 1+1 afterwards returns 0x00000002.
